// File: rtl/hdmi_island_sched.sv
// rtl/hdmi_island_sched.sv - data-island packet scheduler: control, audio sample and null packets per slot
module hdmi_island_sched #(
    parameter int           LINES_PER_CYCLE = 45,
    parameter int           PKTS_PER_LINE   = 3,
    parameter int           ACR_LINE        = 0,
    parameter int           AVI_LINE        = 37,
    parameter int           SPD_LINE        = 38,
    parameter int           AUD_LINE        = 39,
    parameter logic [247:0] ACR_PKT         = 248'h0,
    parameter logic [247:0] AVI_PKT         = 248'h0,
    parameter logic [247:0] SPD_PKT         = 248'h0,
    parameter logic [247:0] AUD_PKT         = 248'h0,
    parameter int           FIFO_DEPTH      = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         hsync,
    input  logic         aud_valid,
    output logic         aud_ready,
    input  logic [23:0]  aud_l,
    input  logic [23:0]  aud_r,
    input  logic         slot_req,
    output logic         pkt_valid,
    output logic [23:0]  pkt_hdr,
    output logic [223:0] pkt_sub,
    output logic [2:0]   pkt_type,
    output logic         slot_ovf
);
    localparam int LINE_W = $clog2(LINES_PER_CYCLE);
    localparam int SLOT_W = $clog2(PKTS_PER_LINE + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [2:0] {
        PT_NULL  = 3'd0,
        PT_AUDIO = 3'd1,
        PT_ACR   = 3'd2,
        PT_AVI   = 3'd3,
        PT_SPD   = 3'd4,
        PT_AUDIF = 3'd5
    } pkt_type_t;

    logic              hsync_d;
    logic [LINE_W-1:0] line_q, line_cur;
    logic [SLOT_W-1:0] slot_q, slot_cur;
    logic              ctl_done_q, ctl_done_cur;
    logic              line_edge;

    logic [47:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic              ctl_hit;
    pkt_type_t         ctl_kind;
    logic [247:0]      ctl_pkt;
    logic              in_range, ctl_pending, grant_ctl, grant_aud, push;

    assign line_edge = hsync & ~hsync_d;

    // A line edge takes effect before any request arriving in the same cycle.
    always_comb begin
        line_cur     = line_q;
        slot_cur     = slot_q;
        ctl_done_cur = ctl_done_q;
        if (line_edge) begin
            line_cur     = (line_q == LINE_W'(LINES_PER_CYCLE - 1)) ? '0 : line_q + 1'b1;
            slot_cur     = '0;
            ctl_done_cur = 1'b0;
        end
    end

    always_comb begin
        ctl_hit  = 1'b1;
        ctl_kind = PT_NULL;
        ctl_pkt  = '0;
        if (line_cur == LINE_W'(ACR_LINE)) begin
            ctl_kind = PT_ACR;
            ctl_pkt  = ACR_PKT;
        end else if (line_cur == LINE_W'(AVI_LINE)) begin
            ctl_kind = PT_AVI;
            ctl_pkt  = AVI_PKT;
        end else if (line_cur == LINE_W'(SPD_LINE)) begin
            ctl_kind = PT_SPD;
            ctl_pkt  = SPD_PKT;
        end else if (line_cur == LINE_W'(AUD_LINE)) begin
            ctl_kind = PT_AUDIF;
            ctl_pkt  = AUD_PKT;
        end else begin
            ctl_hit  = 1'b0;
        end
    end

    // The empty test uses the registered count, so a same-cycle push cannot be popped.
    assign in_range    = slot_cur < SLOT_W'(PKTS_PER_LINE);
    assign ctl_pending = ctl_hit & ~ctl_done_cur;
    assign grant_ctl   = slot_req & in_range & ctl_pending;
    assign grant_aud   = slot_req & in_range & ~ctl_pending & (count_q != '0);
    assign aud_ready   = count_q != CNT_W'(FIFO_DEPTH);
    assign push        = aud_valid & aud_ready;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= {aud_r, aud_l};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hsync_d    <= 1'b0;
            line_q     <= '0;
            slot_q     <= '0;
            ctl_done_q <= 1'b0;
            slot_ovf   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pkt_valid  <= 1'b0;
            pkt_hdr    <= '0;
            pkt_sub    <= '0;
            pkt_type   <= PT_NULL;
        end else begin
            hsync_d    <= hsync;
            line_q     <= line_cur;
            ctl_done_q <= ctl_done_cur | grant_ctl;
            slot_q     <= (slot_req & in_range) ? slot_cur + 1'b1 : slot_cur;
            if (slot_req & ~in_range)
                slot_ovf <= 1'b1;

            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (grant_aud)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push & ~grant_aud)
                count_q <= count_q + 1'b1;
            else if (~push & grant_aud)
                count_q <= count_q - 1'b1;

            pkt_valid <= slot_req;
            if (slot_req) begin
                if (grant_ctl) begin
                    pkt_hdr  <= ctl_pkt[247:224];
                    pkt_sub  <= ctl_pkt[223:0];
                    pkt_type <= ctl_kind;
                end else if (grant_aud) begin
                    pkt_hdr  <= 24'h000102;
                    pkt_sub  <= {176'h0, mem[rd_ptr_q]};
                    pkt_type <= PT_AUDIO;
                end else begin
                    pkt_hdr  <= '0;
                    pkt_sub  <= '0;
                    pkt_type <= PT_NULL;
                end
            end
        end
    end
endmodule

// File: tb/tb_hdmi_island_sched.sv
// tb/tb_hdmi_island_sched.sv - directed self-checking bench for hdmi_island_sched
module tb_hdmi_island_sched;
    localparam logic [247:0] ACR_P = {24'h000001, {28{8'hA1}}};
    localparam logic [247:0] AVI_P = {24'h0D0282, {28{8'hB2}}};
    localparam logic [247:0] SPD_P = {24'h190183, {28{8'hC3}}};
    localparam logic [247:0] AUD_P = {24'h0A0184, {28{8'hD4}}};

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         hsync = 1'b0;
    logic         aud_valid = 1'b0;
    logic [23:0]  aud_l = '0;
    logic [23:0]  aud_r = '0;
    logic         slot_req = 1'b0;
    logic         aud_ready, pkt_valid, slot_ovf;
    logic [23:0]  pkt_hdr;
    logic [223:0] pkt_sub;
    logic [2:0]   pkt_type;
    logic         d_aud_ready, d_pkt_valid, d_slot_ovf;
    logic [23:0]  d_pkt_hdr;
    logic [223:0] d_pkt_sub;
    logic [2:0]   d_pkt_type;

    int total = 0;
    int bad = 0;

    hdmi_island_sched #(
        .ACR_PKT(ACR_P), .AVI_PKT(AVI_P), .SPD_PKT(SPD_P), .AUD_PKT(AUD_P)
    ) dut (
        .clk(clk), .resetn(resetn), .hsync(hsync), .aud_valid(aud_valid),
        .aud_ready(aud_ready), .aud_l(aud_l), .aud_r(aud_r), .slot_req(slot_req),
        .pkt_valid(pkt_valid), .pkt_hdr(pkt_hdr), .pkt_sub(pkt_sub),
        .pkt_type(pkt_type), .slot_ovf(slot_ovf)
    );

    // AVI shares line 0 with ACR here: ACR must win and AVI is never sent.
    hdmi_island_sched #(
        .AVI_LINE(0), .ACR_PKT(ACR_P), .AVI_PKT(AVI_P), .SPD_PKT(SPD_P), .AUD_PKT(AUD_P)
    ) dut_dup (
        .clk(clk), .resetn(resetn), .hsync(hsync), .aud_valid(aud_valid),
        .aud_ready(d_aud_ready), .aud_l(aud_l), .aud_r(aud_r), .slot_req(slot_req),
        .pkt_valid(d_pkt_valid), .pkt_hdr(d_pkt_hdr), .pkt_sub(d_pkt_sub),
        .pkt_type(d_pkt_type), .slot_ovf(d_slot_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; hsync = 1'b0; slot_req = 1'b0; aud_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic pulse_hsync();
        @(negedge clk);
        hsync = 1'b1;
        @(negedge clk);
        hsync = 1'b0;
    endtask

    task automatic do_req(output logic v_before, output logic v_after);
        @(negedge clk);
        v_before = pkt_valid;
        slot_req = 1'b1;
        @(negedge clk);
        slot_req = 1'b0;
        v_after = pkt_valid;
    endtask

    task automatic push_samples(input int n, input logic [23:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            aud_valid = 1'b1;
            aud_l = base + 24'(i);
            aud_r = 24'hF00000 + base + 24'(i);
        end
        @(negedge clk);
        aud_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h want=0", pkt_valid); end
        total++; if (pkt_hdr !== 24'h0) begin bad++; $display("FAIL rst_hdr got=%0h want=0", pkt_hdr); end
        total++; if (pkt_sub !== 224'h0) begin bad++; $display("FAIL rst_sub got=%0h want=0", pkt_sub); end
        total++; if (pkt_type !== 3'd0) begin bad++; $display("FAIL rst_type got=%0d want=0", pkt_type); end
        total++; if (slot_ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%0h want=0", slot_ovf); end
        total++; if (aud_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0h want=1", aud_ready); end
    endtask

    task automatic test_control_cycle();
        logic vb, va;
        logic [2:0] et;
        logic [247:0] ep;
        do_reset();
        for (int l = 0; l <= 45; l++) begin
            if (l > 0) pulse_hsync();
            for (int s = 0; s < 3; s++) begin
                do_req(vb, va);
                et = 3'd0; ep = '0;
                if (s == 0) begin
                    case (l % 45)
                        0:  begin et = 3'd2; ep = ACR_P; end
                        37: begin et = 3'd3; ep = AVI_P; end
                        38: begin et = 3'd4; ep = SPD_P; end
                        39: begin et = 3'd5; ep = AUD_P; end
                        default: ;
                    endcase
                end
                total++; if (vb !== 1'b0 || va !== 1'b1) begin bad++; $display("FAIL ctl_latency line=%0d slot=%0d got=%b%b want=01", l, s, vb, va); end
                total++; if (pkt_type !== et) begin bad++; $display("FAIL ctl_type line=%0d slot=%0d got=%0d want=%0d", l, s, pkt_type, et); end
                total++; if ({pkt_hdr, pkt_sub} !== ep) begin bad++; $display("FAIL ctl_pkt line=%0d slot=%0d got=%0h want=%0h", l, s, pkt_hdr, ep[247:224]); end
                if (s == 0 && (l == 0 || l == 37)) begin
                    total++; if (d_pkt_type !== ((l == 0) ? 3'd2 : 3'd0)) begin bad++; $display("FAIL ctl_coincide line=%0d got=%0d want=%0d", l, d_pkt_type, (l == 0) ? 2 : 0); end
                end
            end
        end
    endtask

    task automatic test_audio_order();
        logic vb, va;
        logic [23:0] exp_l [6] = '{24'h1, 24'h2, 24'h3, 24'h4, 24'h5, 24'h0};
        do_reset();
        push_samples(5, 24'h1);
        for (int k = 0; k < 6; k++) begin
            if (k % 3 == 0) pulse_hsync();
            do_req(vb, va);
            if (k < 5) begin
                total++; if (pkt_type !== 3'd1) begin bad++; $display("FAIL aud_type k=%0d got=%0d want=1", k, pkt_type); end
                total++; if (pkt_hdr !== 24'h000102) begin bad++; $display("FAIL aud_hdr k=%0d got=%0h want=102", k, pkt_hdr); end
                total++; if (pkt_sub[23:0] !== exp_l[k]) begin bad++; $display("FAIL aud_left k=%0d got=%0h want=%0h", k, pkt_sub[23:0], exp_l[k]); end
                total++; if (pkt_sub[47:24] !== 24'hF00000 + exp_l[k]) begin bad++; $display("FAIL aud_right k=%0d got=%0h want=%0h", k, pkt_sub[47:24], 24'hF00000 + exp_l[k]); end
                total++; if (pkt_sub[223:48] !== 176'h0) begin bad++; $display("FAIL aud_upper k=%0d got=%0h want=0", k, pkt_sub[223:48]); end
            end else begin
                total++; if (pkt_type !== 3'd0 || pkt_sub !== 224'h0 || pkt_hdr !== 24'h0) begin bad++; $display("FAIL aud_null type=%0d hdr=%0h want type=0 hdr=0", pkt_type, pkt_hdr); end
            end
        end
    endtask

    task automatic test_fifo_full();
        logic vb, va;
        logic [23:0] exp_l [8] = '{24'd2, 24'd3, 24'd4, 24'd5, 24'd6, 24'd7, 24'd8, 24'd99};
        do_reset();
        @(negedge clk);
        aud_valid = 1'b1; aud_l = 24'd1; aud_r = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            total++; if (aud_ready !== (k < 8)) begin bad++; $display("FAIL full_ready pushes=%0d got=%0h want=%0h", k, aud_ready, k < 8); end
            aud_l = 24'(k + 1);
        end
        aud_valid = 1'b0;
        pulse_hsync();
        @(negedge clk);
        aud_valid = 1'b1; aud_l = 24'd99; slot_req = 1'b1;
        @(negedge clk);
        slot_req = 1'b0;
        total++; if (pkt_type !== 3'd1 || pkt_sub[23:0] !== 24'd1) begin bad++; $display("FAIL full_grant type=%0d left=%0h want type=1 left=1", pkt_type, pkt_sub[23:0]); end
        total++; if (aud_ready !== 1'b1) begin bad++; $display("FAIL full_reopen got=%0h want=1", aud_ready); end
        @(negedge clk);
        aud_valid = 1'b0;
        total++; if (aud_ready !== 1'b0) begin bad++; $display("FAIL full_refill got=%0h want=0", aud_ready); end
        for (int k = 0; k < 9; k++) begin
            if (k == 2 || k == 5 || k == 8) pulse_hsync();
            do_req(vb, va);
            if (k < 8) begin
                total++; if (pkt_type !== 3'd1 || pkt_sub[23:0] !== exp_l[k]) begin bad++; $display("FAIL full_drain k=%0d type=%0d left=%0h want type=1 left=%0h", k, pkt_type, pkt_sub[23:0], exp_l[k]); end
            end else begin
                total++; if (pkt_type !== 3'd0) begin bad++; $display("FAIL full_empty got=%0d want=0", pkt_type); end
            end
        end
    endtask

    task automatic test_overflow();
        logic vb, va;
        do_reset();
        pulse_hsync();
        for (int i = 0; i < 4; i++) begin
            do_req(vb, va);
            total++; if (pkt_type !== 3'd0 || va !== 1'b1) begin bad++; $display("FAIL ovf_pkt i=%0d type=%0d valid=%0h want type=0 valid=1", i, pkt_type, va); end
            total++; if (slot_ovf !== (i == 3)) begin bad++; $display("FAIL ovf_flag i=%0d got=%0h want=%0h", i, slot_ovf, i == 3); end
        end
        push_samples(1, 24'h55);
        pulse_hsync();
        do_req(vb, va);
        total++; if (pkt_type !== 3'd1 || pkt_sub[23:0] !== 24'h55) begin bad++; $display("FAIL ovf_next type=%0d left=%0h want type=1 left=55", pkt_type, pkt_sub[23:0]); end
        total++; if (slot_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0h want=1", slot_ovf); end
    endtask

    task automatic test_reset_midline();
        logic vb, va;
        do_reset();
        pulse_hsync();
        push_samples(3, 24'h21);
        do_req(vb, va);
        total++; if (pkt_type !== 3'd1 || pkt_sub[23:0] !== 24'h21) begin bad++; $display("FAIL mid_pre type=%0d left=%0h want type=1 left=21", pkt_type, pkt_sub[23:0]); end
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        total++; if (pkt_valid !== 1'b0 || pkt_type !== 3'd0 || pkt_hdr !== 24'h0 || pkt_sub !== 224'h0) begin bad++; $display("FAIL mid_outputs type=%0d hdr=%0h want all zero", pkt_type, pkt_hdr); end
        total++; if (aud_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%0h want=1", aud_ready); end
        @(negedge clk);
        resetn = 1'b1;
        do_req(vb, va);
        total++; if (pkt_type !== 3'd2 || pkt_hdr !== ACR_P[247:224]) begin bad++; $display("FAIL mid_acr type=%0d hdr=%0h want type=2 hdr=%0h", pkt_type, pkt_hdr, ACR_P[247:224]); end
        for (int i = 0; i < 2; i++) begin
            do_req(vb, va);
            total++; if (pkt_type !== 3'd0) begin bad++; $display("FAIL mid_flushed i=%0d got=%0d want=0", i, pkt_type); end
        end
    endtask

    task automatic test_edge_coincident();
        logic vb, va;
        do_reset();
        for (int i = 0; i < 44; i++) pulse_hsync();
        for (int i = 0; i < 3; i++) do_req(vb, va);
        push_samples(1, 24'h77);
        @(negedge clk);
        hsync = 1'b1; slot_req = 1'b1;
        @(negedge clk);
        hsync = 1'b0; slot_req = 1'b0;
        total++; if (pkt_valid !== 1'b1 || pkt_type !== 3'd2) begin bad++; $display("FAIL coin_acr valid=%0h type=%0d want valid=1 type=2", pkt_valid, pkt_type); end
        total++; if (slot_ovf !== 1'b0) begin bad++; $display("FAIL coin_ovf got=%0h want=0", slot_ovf); end
        do_req(vb, va);
        total++; if (pkt_type !== 3'd1 || pkt_sub[23:0] !== 24'h77) begin bad++; $display("FAIL coin_audio type=%0d left=%0h want type=1 left=77", pkt_type, pkt_sub[23:0]); end
        do_req(vb, va);
        total++; if (pkt_type !== 3'd0) begin bad++; $display("FAIL coin_null got=%0d want=0", pkt_type); end
        total++; if (slot_ovf !== 1'b0) begin bad++; $display("FAIL coin_ovf_end got=%0h want=0", slot_ovf); end
    endtask

    initial begin
        test_reset();
        test_control_cycle();
        test_audio_order();
        test_fifo_full();
        test_overflow();
        test_reset_midline();
        test_edge_coincident();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
